// File: rtl/nvdla_package.sv
// Shared types for the DBB <-> HWPE stream bridge: channel structs, streamer
// control/flag structs and the bridge FSM state encoding.
package nvdla_package;

    localparam int unsigned DbbDataW  = 64;
    localparam int unsigned DbbAddrW  = 32;
    localparam int unsigned DbbLenW   = 4;
    localparam int unsigned DbbIdW    = 8;
    localparam int unsigned DbbStrbW  = DbbDataW / 8;
    localparam int unsigned DbbTransW = DbbLenW + 1;

    typedef struct packed {
        logic                valid;
        logic [DbbAddrW-1:0] addr;
        logic [DbbLenW-1:0]  len;
        logic [DbbIdW-1:0]   id;
    } dbb_req_t;

    typedef struct packed {
        logic                valid;
        logic [DbbDataW-1:0] data;
        logic [DbbStrbW-1:0] strb;
        logic                last;
    } dbb_wdat_t;

    typedef struct packed {
        logic              valid;
        logic [DbbIdW-1:0] id;
        logic              err;
    } dbb_rsp_t;

    typedef struct packed {
        logic                valid;
        logic [DbbDataW-1:0] data;
        logic [DbbIdW-1:0]   id;
        logic                last;
    } dbb_rdat_t;

    typedef struct packed {
        logic                 req_start;
        logic [DbbAddrW-1:0]  base_addr;
        logic [DbbTransW-1:0] trans_size;
    } stream_ctrl_t;

    typedef struct packed {
        stream_ctrl_t sink;
        stream_ctrl_t source;
    } ctrl_streamer_t;

    typedef struct packed {
        logic ready_start;
    } stream_flags_t;

    typedef struct packed {
        stream_flags_t sink;
        stream_flags_t source;
    } flags_streamer_t;

    typedef enum logic [2:0] {
        StIdle,
        StWrStart,
        StWrData,
        StWrRsp,
        StRdStart,
        StRdData,
        StRdTerm
    } dbb_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready data stream with byte strobes, as used by the HWPE streamers.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink (input valid, input data, input strb, output ready);
endinterface

// File: rtl/nvdla_dbb_rr_arb.sv
// Two-way round-robin arbiter (bit 0 = write, bit 1 = read). The pointer flips on
// every grant, so a lone requester also hands priority to the other side.
module nvdla_dbb_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = 1'b0;
        end else if (|gnt_o) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/nvdla_dbb_stream_bridge.sv
// Bridges DBB read/write bursts onto HWPE sink/source streamers.
// Define NVDLA_DBB_LAST_CHECK_EN to flag wr_dat_i.last mismatches in wr_rsp_o.err.
module nvdla_dbb_stream_bridge
    import nvdla_package::*;
#(
    parameter int unsigned DATA_W = DbbDataW,
    parameter int unsigned ADDR_W = DbbAddrW,
    parameter int unsigned LEN_W  = DbbLenW,
    parameter int unsigned ID_W   = DbbIdW
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  dbb_req_t               wr_req_i,
    output logic                   wr_req_ready_o,
    input  dbb_req_t               rd_req_i,
    output logic                   rd_req_ready_o,
    input  dbb_wdat_t              wr_dat_i,
    output logic                   wr_dat_ready_o,
    output dbb_rsp_t               wr_rsp_o,
    input  logic                   wr_rsp_ready_i,
    output dbb_rdat_t              rd_dat_o,
    input  logic                   rd_dat_ready_i,
    output ctrl_streamer_t         ctrl_streamer_o,
    input  flags_streamer_t        flags_streamer_i,
    hwpe_stream_intf_stream.source dbb_o,
    hwpe_stream_intf_stream.sink   dbb_i
);
    localparam int unsigned TRANS_W = LEN_W + 1;

    dbb_state_e         state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               err_q, err_d;
    logic [1:0]         gnt;
    logic [DATA_W-1:0]  rd_data;
    logic [TRANS_W-1:0] trans_size;
    logic               last_beat, wr_fire, rd_fire, rsp_valid, last_mismatch;
    logic               unused_rd_strb;

    nvdla_dbb_rr_arb u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .en_i    ((state_q == StIdle) && !clear_i),
        .req_i   ({rd_req_i.valid, wr_req_i.valid}),
        .gnt_o   (gnt)
    );

    // Termination uses the counter only; the counter may wrap after the final beat.
    assign last_beat  = (cnt_q == len_q);
    assign trans_size = TRANS_W'(len_q) + TRANS_W'(1);

    assign dbb_o.valid    = (state_q == StWrData) && wr_dat_i.valid;
    assign dbb_o.data     = wr_dat_i.data;
    assign dbb_o.strb     = wr_dat_i.strb;
    assign wr_dat_ready_o = (state_q == StWrData) && dbb_o.ready;
    assign wr_fire        = dbb_o.valid && dbb_o.ready;

    assign dbb_i.ready    = (state_q == StRdData) && rd_dat_ready_i;
    assign rd_fire        = dbb_i.valid && dbb_i.ready;
    assign rd_data        = dbb_i.data;
    assign unused_rd_strb = ^dbb_i.strb;

    // Once the sink signals ready_start the response stays valid until accepted.
    assign rsp_valid = (state_q == StWrRsp) && (rsp_vld_q || flags_streamer_i.sink.ready_start);

`ifdef NVDLA_DBB_LAST_CHECK_EN
    assign last_mismatch = wr_dat_i.last ^ last_beat;
`else
    logic unused_last;
    assign last_mismatch = 1'b0;
    assign unused_last   = wr_dat_i.last;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        addr_d    = addr_q;
        id_d      = id_q;
        rsp_vld_d = rsp_vld_q;
        err_d     = err_q;

        wr_req_ready_o = gnt[0];
        rd_req_ready_o = gnt[1];

        ctrl_streamer_o.sink.req_start    = 1'b0;
        ctrl_streamer_o.sink.base_addr    = addr_q;
        ctrl_streamer_o.sink.trans_size   = trans_size;
        ctrl_streamer_o.source.req_start  = 1'b0;
        ctrl_streamer_o.source.base_addr  = addr_q;
        ctrl_streamer_o.source.trans_size = trans_size;

        wr_rsp_o.valid = rsp_valid;
        wr_rsp_o.id    = id_q;
        wr_rsp_o.err   = err_q;

        rd_dat_o.valid = (state_q == StRdData) && dbb_i.valid;
        rd_dat_o.data  = rd_data;
        rd_dat_o.id    = id_q;
        rd_dat_o.last  = last_beat;

        case (state_q)
            StIdle: begin
                if (gnt[0]) begin
                    addr_d  = wr_req_i.addr;
                    len_d   = wr_req_i.len;
                    id_d    = wr_req_i.id;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StWrStart;
                end else if (gnt[1]) begin
                    addr_d  = rd_req_i.addr;
                    len_d   = rd_req_i.len;
                    id_d    = rd_req_i.id;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StRdStart;
                end
            end
            StWrStart: begin
                if (flags_streamer_i.sink.ready_start) begin
                    ctrl_streamer_o.sink.req_start = 1'b1;
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_mismatch) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StWrRsp;
                    end
                end
            end
            StWrRsp: begin
                if (rsp_valid) begin
                    rsp_vld_d = 1'b1;
                    if (wr_rsp_ready_i) begin
                        rsp_vld_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            StRdStart: begin
                if (flags_streamer_i.source.ready_start) begin
                    ctrl_streamer_o.source.req_start = 1'b1;
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (rd_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = StRdTerm;
                    end
                end
            end
            StRdTerm: begin
                if (flags_streamer_i.source.ready_start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Soft clear drops any burst in flight without a response.
        if (clear_i) begin
            state_d   = StIdle;
            cnt_d     = '0;
            len_d     = '0;
            addr_d    = '0;
            id_d      = '0;
            rsp_vld_d = 1'b0;
            err_d     = 1'b0;
            ctrl_streamer_o.sink.req_start   = 1'b0;
            ctrl_streamer_o.source.req_start = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            rsp_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            rsp_vld_q <= rsp_vld_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_nvdla_dbb_stream_bridge.sv
// Self-checking bench for nvdla_dbb_stream_bridge: directed bursts plus randomized
// traffic and backpressure against a transaction-level reference model.
module tb_nvdla_dbb_stream_bridge;
    import nvdla_package::*;

    logic            clk_i  = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clear_i;
    dbb_req_t        wr_req_i, rd_req_i;
    logic            wr_req_ready_o, rd_req_ready_o;
    dbb_wdat_t       wr_dat_i;
    logic            wr_dat_ready_o;
    dbb_rsp_t        wr_rsp_o;
    logic            wr_rsp_ready_i;
    dbb_rdat_t       rd_dat_o;
    logic            rd_dat_ready_i;
    ctrl_streamer_t  ctrl;
    flags_streamer_t flags;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DbbDataW)) dbb_wr ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DbbDataW)) dbb_rd ();

    nvdla_dbb_stream_bridge dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .wr_req_i         (wr_req_i),
        .wr_req_ready_o   (wr_req_ready_o),
        .rd_req_i         (rd_req_i),
        .rd_req_ready_o   (rd_req_ready_o),
        .wr_dat_i         (wr_dat_i),
        .wr_dat_ready_o   (wr_dat_ready_o),
        .wr_rsp_o         (wr_rsp_o),
        .wr_rsp_ready_i   (wr_rsp_ready_i),
        .rd_dat_o         (rd_dat_o),
        .rd_dat_ready_i   (rd_dat_ready_i),
        .ctrl_streamer_o  (ctrl),
        .flags_streamer_i (flags),
        .dbb_o            (dbb_wr),
        .dbb_i            (dbb_rd)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit rr_rd    = 1'b0;  // model: 1 when read has priority on a tie

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i        = 1'b0;
        wr_req_i       = '0;
        rd_req_i       = '0;
        wr_dat_i       = '0;
        wr_rsp_ready_i = 1'b0;
        rd_dat_ready_i = 1'b0;
        flags          = '0;
        dbb_wr.ready   = 1'b0;
        dbb_rd.valid   = 1'b0;
        dbb_rd.data    = '0;
        dbb_rd.strb    = '0;
    endtask

    function automatic dbb_req_t mkreq(input logic [31:0] a, input logic [3:0] l,
                                       input logic [7:0] i);
        dbb_req_t r;
        r.valid = 1'b1;
        r.addr  = a;
        r.len   = l;
        r.id    = i;
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_wr_req_ready"}, wr_req_ready_o, 0);
        check_eq({tag, "_rd_req_ready"}, rd_req_ready_o, 0);
        check_eq({tag, "_dbb_o_valid"}, dbb_wr.valid, 0);
        check_eq({tag, "_wr_dat_ready"}, wr_dat_ready_o, 0);
        check_eq({tag, "_wr_rsp_valid"}, wr_rsp_o.valid, 0);
        check_eq({tag, "_rd_dat_valid"}, rd_dat_o.valid, 0);
        check_eq({tag, "_dbb_i_ready"}, dbb_rd.ready, 0);
        check_eq({tag, "_sink_start"}, ctrl.sink.req_start, 0);
        check_eq({tag, "_src_start"}, ctrl.source.req_start, 0);
        check_eq({tag, "_base_addr"}, ctrl.sink.base_addr, 0);
        check_eq({tag, "_trans_size"}, ctrl.sink.trans_size, 1);
        check_eq({tag, "_rd_id"}, rd_dat_o.id, 0);
    endtask

    // Issue request(s) in IDLE; the model decides who must be granted.
    task automatic request(input bit wv, input bit rv, input dbb_req_t wq, input dbb_req_t rq,
                           output bit got_wr);
        bit exp_wr;
        wr_req_i       = wq;
        wr_req_i.valid = wv;
        rd_req_i       = rq;
        rd_req_i.valid = rv;
        exp_wr = (wv && rv) ? !rr_rd : wv;
        #1;
        check_eq("wr_req_ready", wr_req_ready_o, exp_wr);
        check_eq("rd_req_ready", rd_req_ready_o, !exp_wr);
        rr_rd  = !rr_rd;
        got_wr = exp_wr;
        tick();
        wr_req_i.valid = 1'b0;
        rd_req_i.valid = 1'b0;
    endtask

    task automatic start_phase(input bit is_wr, input dbb_req_t req, input int stall);
        stream_ctrl_t c;
        for (int i = 0; i < stall; i++) begin
            #1;
            c = is_wr ? ctrl.sink : ctrl.source;
            check_eq("start_early", c.req_start, 0);
            tick();
        end
        if (is_wr) flags.sink.ready_start = 1'b1;
        else flags.source.ready_start = 1'b1;
        #1;
        c = is_wr ? ctrl.sink : ctrl.source;
        check_eq("req_start", c.req_start, 1);
        check_eq("base_addr", c.base_addr, req.addr);
        check_eq("trans_size", c.trans_size, 64'(req.len) + 64'd1);
        tick();
        flags = '0;
        #1;
        c = is_wr ? ctrl.sink : ctrl.source;
        check_eq("start_once", c.req_start, 0);
    endtask

    task automatic write_body(input dbb_req_t req, input logic [15:0] last_mask, input bit stalls);
        logic [63:0] beats[$];
        logic [7:0]  strbs[$];
        int idx = 0;
        int cyc = 0;
        bit exp_err = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i <= int'(req.len); i++) begin
            beats.push_back({$urandom, $urandom});
            strbs.push_back(8'($urandom));
        end
`ifdef NVDLA_DBB_LAST_CHECK_EN
        for (int i = 0; i <= int'(req.len); i++) begin
            if (last_mask[i] != (i == int'(req.len))) exp_err = 1'b1;
        end
`endif
        start_phase(1'b1, req, stalls ? int'($urandom_range(0, 2)) : 0);
        while (idx <= int'(req.len) && cyc < 300) begin
            wr_dat_i.data  = beats[idx];
            wr_dat_i.strb  = strbs[idx];
            wr_dat_i.last  = last_mask[idx];
            wr_dat_i.valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            dbb_wr.ready   = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            check_eq("dbb_o_valid", dbb_wr.valid, wr_dat_i.valid);
            check_eq("wr_dat_ready", wr_dat_ready_o, dbb_wr.ready);
            if (dbb_wr.valid && dbb_wr.ready) begin
                check_eq("dbb_o_data", dbb_wr.data, beats[idx]);
                check_eq("dbb_o_strb", dbb_wr.strb, strbs[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        if (idx <= int'(req.len)) check_eq("wr_data_timeout", idx, req.len + 1);
        // Burst must be over: extra beats and new requests are refused.
        wr_dat_i.valid = 1'b1;
        dbb_wr.ready   = 1'b1;
        wr_req_i.valid = 1'b1;
        for (int i = 0; i < 1 + (stalls ? int'($urandom_range(0, 2)) : 0); i++) begin
            #1;
            check_eq("wr_extra_beat", dbb_wr.valid, 0);
            check_eq("wr_busy_no_grant", wr_req_ready_o, 0);
            check_eq("wr_rsp_early", wr_rsp_o.valid, 0);
            tick();
        end
        wr_dat_i.valid = 1'b0;
        dbb_wr.ready   = 1'b0;
        wr_req_i.valid = 1'b0;
        flags.sink.ready_start = 1'b1;
        cyc = 0;
        while (!done && cyc < 50) begin
            wr_rsp_ready_i = stalls ? ($urandom_range(0, 2) == 0) : 1'b1;
            #1;
            check_eq("wr_rsp_valid", wr_rsp_o.valid, 1);
            check_eq("wr_rsp_id", wr_rsp_o.id, req.id);
            check_eq("wr_rsp_err", wr_rsp_o.err, exp_err);
            done = wr_rsp_ready_i;
            tick();
            cyc++;
        end
        if (!done) check_eq("wr_rsp_timeout", cyc, 0);
        flags = '0;
        wr_rsp_ready_i = 1'b0;
        #1;
        check_eq("wr_rsp_single", wr_rsp_o.valid, 0);
    endtask

    task automatic read_body(input dbb_req_t req, input bit stalls, input int clear_at);
        logic [63:0] mem[$];
        int idx = 0;
        int cyc = 0;
        bit cleared = 1'b0;
        for (int i = 0; i <= int'(req.len); i++) mem.push_back({$urandom, $urandom});
        start_phase(1'b0, req, stalls ? int'($urandom_range(0, 2)) : 0);
        while (idx <= int'(req.len) && cyc < 300 && !cleared) begin
            dbb_rd.data    = mem[idx];
            dbb_rd.strb    = '1;
            dbb_rd.valid   = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            rd_dat_ready_i = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            clear_i        = (idx == clear_at);
            #1;
            check_eq("rd_dat_valid", rd_dat_o.valid, dbb_rd.valid);
            check_eq("dbb_i_ready", dbb_rd.ready, rd_dat_ready_i);
            if (rd_dat_o.valid && rd_dat_ready_i) begin
                check_eq("rd_dat_data", rd_dat_o.data, mem[idx]);
                check_eq("rd_dat_id", rd_dat_o.id, req.id);
                check_eq("rd_dat_last", rd_dat_o.last, idx == int'(req.len));
                idx++;
            end
            cleared = clear_i;
            tick();
            cyc++;
        end
        if (cleared) begin
            clear_i        = 1'b0;
            rr_rd          = 1'b0;
            dbb_rd.valid   = 1'b1;
            rd_dat_ready_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                check_quiet("after_clear");
                tick();
            end
            dbb_rd.valid   = 1'b0;
            rd_dat_ready_i = 1'b0;
            return;
        end
        if (idx <= int'(req.len)) check_eq("rd_data_timeout", idx, req.len + 1);
        dbb_rd.valid   = 1'b1;
        rd_dat_ready_i = 1'b1;
        rd_req_i.valid = 1'b1;
        for (int i = 0; i < 1 + (stalls ? int'($urandom_range(0, 2)) : 0); i++) begin
            #1;
            check_eq("rd_extra_beat", rd_dat_o.valid, 0);
            check_eq("rd_busy_no_grant", rd_req_ready_o, 0);
            tick();
        end
        dbb_rd.valid   = 1'b0;
        rd_dat_ready_i = 1'b0;
        rd_req_i.valid = 1'b0;
        flags.source.ready_start = 1'b1;
        tick();
        flags = '0;
    endtask

    initial begin
        dbb_req_t    wq, rq;
        bit          gw;
        bit          wv, rv;
        logic [3:0]  len;
        logic [15:0] mask;
        bit          exp_seq[3] = '{1'b1, 1'b0, 1'b1};

        idle_inputs();
        repeat (3) @(posedge clk_i);
        #1;
        check_quiet("reset");
        rst_ni = 1'b1;
        tick();

        // Directed write: addr 0x100, len 3, id 0x5A, no stalls.
        wq = mkreq(32'h100, 4'd3, 8'h5A);
        request(1'b1, 1'b0, wq, '0, gw);
        write_body(wq, 16'h0008, 1'b0);

        // Directed single-beat read with data 0xDEAD.
        rq = mkreq(32'h2000, 4'd0, 8'h11);
        request(1'b0, 1'b1, '0, rq, gw);
        start_phase(1'b0, rq, 0);
        dbb_rd.data    = 64'hDEAD;
        dbb_rd.valid   = 1'b1;
        rd_dat_ready_i = 1'b1;
        #1;
        check_eq("rd0_data", rd_dat_o.data, 64'hDEAD);
        check_eq("rd0_valid", rd_dat_o.valid, 1);
        check_eq("rd0_last", rd_dat_o.last, 1);
        check_eq("rd0_id", rd_dat_o.id, 8'h11);
        tick();
        #1;
        check_eq("rd0_single", rd_dat_o.valid, 0);
        dbb_rd.valid   = 1'b0;
        rd_dat_ready_i = 1'b0;
        flags.source.ready_start = 1'b1;
        tick();
        flags = '0;

        // Both requesters on consecutive idles: write, read, write.
        for (int k = 0; k < 3; k++) begin
            wq = mkreq($urandom, 4'($urandom_range(0, 3)), 8'($urandom));
            rq = mkreq($urandom, 4'($urandom_range(0, 3)), 8'($urandom));
            request(1'b1, 1'b1, wq, rq, gw);
            check_eq("rr_seq", gw, exp_seq[k]);
            if (gw) write_body(wq, 16'(1) << wq.len, 1'b0);
            else read_body(rq, 1'b0, -1);
        end

        // len 2 with last asserted on beat 1.
        wq = mkreq(32'h300, 4'd2, 8'h33);
        request(1'b1, 1'b0, wq, '0, gw);
        write_body(wq, 16'h0002, 1'b0);

        // Maximum length bursts.
        wq = mkreq(32'h400, 4'd15, 8'h44);
        request(1'b1, 1'b0, wq, '0, gw);
        write_body(wq, 16'h8000, 1'b1);
        rq = mkreq(32'h500, 4'd15, 8'h55);
        request(1'b0, 1'b1, '0, rq, gw);
        read_body(rq, 1'b1, -1);

        // Soft clear during beat 2 of a len 7 read, then normal service.
        rq = mkreq(32'h600, 4'd7, 8'h66);
        request(1'b0, 1'b1, '0, rq, gw);
        read_body(rq, 1'b0, 2);
        wq = mkreq(32'h700, 4'd1, 8'h77);
        request(1'b1, 1'b1, wq, mkreq(32'h780, 4'd1, 8'h78), gw);
        write_body(wq, 16'h0002, 1'b0);
        rq = mkreq(32'h800, 4'd2, 8'h88);
        request(1'b0, 1'b1, '0, rq, gw);
        read_body(rq, 1'b0, -1);

        // Randomized traffic with backpressure.
        for (int n = 0; n < 40; n++) begin
            wv   = 1'($urandom_range(0, 1));
            rv   = !wv || 1'($urandom_range(0, 1));
            len  = 4'($urandom_range(0, 15));
            wq   = mkreq($urandom, len, 8'($urandom));
            rq   = mkreq($urandom, 4'($urandom_range(0, 15)), 8'($urandom));
            mask = 16'(1) << len;
            if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, int'(len))] ^= 1'b1;
            request(wv, rv, wq, rq, gw);
            if (gw) write_body(wq, mask, 1'b1);
            else read_body(rq, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
